// File: rtl/ram_scan_reader.sv
// Read-side scanner for a small synchronous RAM: walks start..end (with wrap-around),
// presents each word over a valid/ready handshake, and keeps a running sum of accepted words.
module ram_scan_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     go,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W-1:0]        end_addr,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic [DATA_W-1:0]        ram_q,
  output logic [DATA_W-1:0]        data_out,
  output logic [ADDR_W-1:0]        data_addr,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic [ADDR_W+DATA_W-1:0] sum,
  output logic                     busy,
  output logic                     done
);

  localparam int SUM_W = ADDR_W + DATA_W;
  // Wide enough to count 0..4, the largest legal read latency.
  localparam int LAT_W = 3;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_READ    = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [LAT_W-1:0]  lat_cnt_q,   lat_cnt_d;
  logic [DATA_W-1:0] data_out_q,  data_out_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [SUM_W-1:0]  sum_q,       sum_d;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    last_addr_d = last_addr_q;
    lat_cnt_d   = lat_cnt_q;
    data_out_d  = data_out_q;
    data_addr_d = data_addr_q;
    sum_d       = sum_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          cur_addr_d  = start_addr;
          last_addr_d = end_addr;
          sum_d       = '0;
          lat_cnt_d   = '0;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        // Address has been stable for RD_LAT+1 cycles once the counter reaches RD_LAT.
        if (lat_cnt_q == LAT_W'(RD_LAT)) begin
          data_out_d  = ram_q;
          data_addr_d = cur_addr_q;
          state_d     = S_PRESENT;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      S_PRESENT: begin
        if (data_ready) begin
          sum_d = sum_q + {{ADDR_W{1'b0}}, data_out_q};
          if (cur_addr_q == last_addr_q) begin
            state_d = S_DONE;
          end else begin
            cur_addr_d = cur_addr_q + ADDR_W'(1);
            lat_cnt_d  = '0;
            state_d    = S_READ;
          end
        end
      end
      S_DONE: begin
        // One scan per press: wait for go to drop before re-arming.
        if (!go) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      last_addr_q <= '0;
      lat_cnt_q   <= '0;
      data_out_q  <= '0;
      data_addr_q <= '0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      last_addr_q <= last_addr_d;
      lat_cnt_q   <= lat_cnt_d;
      data_out_q  <= data_out_d;
      data_addr_q <= data_addr_d;
      sum_q       <= sum_d;
    end
  end

  assign ram_addr   = cur_addr_q;
  assign data_out   = data_out_q;
  assign data_addr  = data_addr_q;
  assign sum        = sum_q;
  assign data_valid = (state_q == S_PRESENT);
  assign busy       = (state_q == S_READ) || (state_q == S_PRESENT);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader: RD_LAT=1 instance with a scoreboarded output stream,
// plus an RD_LAT=3 instance for the latency case.
module tb_ram_scan_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: RD_LAT = 1
  logic       resetn, go, data_ready;
  logic [4:0] start_addr, end_addr, ram_addr, data_addr;
  logic [3:0] ram_q, data_out;
  logic       data_valid, busy, done;
  logic [8:0] sum;

  ram_scan_reader #(.ADDR_W(5), .DATA_W(4), .RD_LAT(1)) dut_a (
    .clk(clk), .resetn(resetn), .go(go), .start_addr(start_addr), .end_addr(end_addr),
    .ram_addr(ram_addr), .ram_q(ram_q), .data_out(data_out), .data_addr(data_addr),
    .data_valid(data_valid), .data_ready(data_ready), .sum(sum), .busy(busy), .done(done)
  );

  logic [3:0] mem_a [32];
  always @(posedge clk) ram_q <= mem_a[ram_addr];

  // Instance B: RD_LAT = 3
  logic       b_resetn, b_go, b_data_ready;
  logic [4:0] b_start_addr, b_end_addr, b_ram_addr, b_data_addr;
  logic [3:0] b_ram_q, b_data_out;
  logic       b_data_valid, b_busy, b_done;
  logic [8:0] b_sum;

  ram_scan_reader #(.ADDR_W(5), .DATA_W(4), .RD_LAT(3)) dut_b (
    .clk(clk), .resetn(b_resetn), .go(b_go), .start_addr(b_start_addr), .end_addr(b_end_addr),
    .ram_addr(b_ram_addr), .ram_q(b_ram_q), .data_out(b_data_out), .data_addr(b_data_addr),
    .data_valid(b_data_valid), .data_ready(b_data_ready), .sum(b_sum), .busy(b_busy), .done(b_done)
  );

  logic [3:0] mem_b [32];
  logic [3:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_b[0] <= mem_b[b_ram_addr];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_ram_q = pipe_b[2];

  // Scoreboard for instance A: {addr, data} pushed by stimulus, popped on each transfer.
  logic [8:0] exp_q [$];
  int         n_xfer      = 0;
  int         last_cyc    = 0;
  bit         spacing_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && data_valid && data_ready) begin
      logic [8:0] e;
      check("sb_has_entry", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("xfer_addr", data_addr, e[8:4]);
        check("xfer_data", data_out, e[3:0]);
      end
      if (spacing_chk && n_xfer > 0) check("xfer_spacing", cyc - last_cyc, 3);
      last_cyc = cyc;
      n_xfer++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int a, input int d);
    exp_q.push_back({a[4:0], d[3:0]});
  endtask

  // Starts a scan on A and checks that the first word appears in the third cycle after go is sampled.
  task automatic start_scan(input int sa, input int ea, input bit hold_go);
    n_xfer     = 0;
    start_addr = sa[4:0];
    end_addr   = ea[4:0];
    go         = 1'b1;
    tick(1);
    if (!hold_go) go = 1'b0;
    check("start_busy", busy, 1);
    check("start_sum_clr", sum, 0);
    check("start_ram_addr", ram_addr, sa[4:0]);
    tick(1);
    check("lat_not_yet", data_valid, 0);
    tick(1);
    check("lat_valid", data_valid, 1);
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (!done && k < max) begin
      tick(1);
      k++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic wait_xfer(input int n, input int max);
    int k = 0;
    while (n_xfer < n && k < max) begin
      tick(1);
      k++;
    end
    check("xfer_count_reached", n_xfer, n);
  endtask

  task automatic wait_valid(input int max);
    int k = 0;
    while (!data_valid && k < max) begin
      tick(1);
      k++;
    end
    check("valid_reached", data_valid, 1);
  endtask

  initial begin
    resetn = 1'b0; go = 1'b0; data_ready = 1'b1; start_addr = '0; end_addr = '0;
    b_resetn = 1'b0; b_go = 1'b0; b_data_ready = 1'b1; b_start_addr = '0; b_end_addr = '0;
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 4'h0;
      mem_b[i] = 4'h0;
    end
    mem_a[3] = 4'hA; mem_a[4] = 4'h1; mem_a[5] = 4'hF; mem_a[6] = 4'h2;
    mem_b[9] = 4'hC;
    tick(3);
    resetn = 1'b1; b_resetn = 1'b1;

    // Reset state
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_data_out", data_out, 0);
    check("rst_data_addr", data_addr, 0);

    // Basic scan 3..6
    spacing_chk = 1'b1;
    push(3, 4'hA); push(4, 4'h1); push(5, 4'hF); push(6, 4'h2);
    start_scan(3, 6, 1'b0);
    wait_done(40);
    check("t1_sum", sum, 9'h1C);
    check("t1_busy_in_done", busy, 0);
    check("t1_sb_empty", exp_q.size(), 0);
    tick(1);
    check("t1_back_idle", done, 0);
    check("t1_sum_kept", sum, 9'h1C);

    // Wrap-around 30..1; also checks sum clears from the previous 0x1C
    mem_a[30] = 4'h5; mem_a[31] = 4'h6; mem_a[0] = 4'h7; mem_a[1] = 4'h8;
    push(30, 5); push(31, 6); push(0, 7); push(1, 8);
    start_scan(30, 1, 1'b0);
    wait_done(40);
    check("t2_sum", sum, 26);
    check("t2_sb_empty", exp_q.size(), 0);
    tick(1);

    // Backpressure on the second word of 3..6
    spacing_chk = 1'b0;
    push(3, 4'hA); push(4, 4'h1); push(5, 4'hF); push(6, 4'h2);
    start_scan(3, 6, 1'b0);
    wait_xfer(1, 20);
    data_ready = 1'b0;
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bp_valid", data_valid, 1);
      check("bp_data", data_out, 4'h1);
      check("bp_addr", data_addr, 5'd4);
      check("bp_sum", sum, 9'hA);
    end
    data_ready = 1'b1;
    wait_done(40);
    check("t3_sum", sum, 9'h1C);
    check("t3_sb_empty", exp_q.size(), 0);
    tick(1);

    // Full 32-word scan with go held through DONE
    spacing_chk = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 4'hF;
      push(i, 4'hF);
    end
    start_scan(0, 31, 1'b1);
    wait_done(200);
    check("t4_sum", sum, 480);
    check("t4_xfers", n_xfer, 32);
    tick(5);
    check("t4_hold_done", done, 1);
    check("t4_hold_busy", busy, 0);
    check("t4_no_restart", n_xfer, 32);
    go = 1'b0;
    tick(1);
    check("t4_release_idle", done, 0);
    check("t4_release_busy", busy, 0);
    check("t4_sb_empty", exp_q.size(), 0);

    // Reset while presenting address 5
    spacing_chk = 1'b0;
    push(3, 4'hF); push(4, 4'hF);
    start_scan(3, 8, 1'b0);
    wait_xfer(2, 20);
    data_ready = 1'b0;
    wait_valid(20);
    check("t5_pres_addr", data_addr, 5'd5);
    check("t5_sb_empty", exp_q.size(), 0);
    resetn = 1'b0;
    tick(1);
    check("t5_rst_valid", data_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_sum", sum, 0);
    check("t5_rst_ram_addr", ram_addr, 0);
    check("t5_rst_data_out", data_out, 0);
    check("t5_rst_data_addr", data_addr, 0);
    resetn = 1'b1;
    data_ready = 1'b1;
    tick(1);
    push(10, 4'hF); push(11, 4'hF);
    start_scan(10, 11, 1'b0);
    wait_done(40);
    check("t5_restart_sum", sum, 9'h1E);
    check("t5_restart_sb_empty", exp_q.size(), 0);
    tick(1);

    // RD_LAT=3 instance: single word at address 9
    b_start_addr = 5'd9; b_end_addr = 5'd9; b_go = 1'b1;
    tick(1);
    b_go = 1'b0;
    check("t6_busy", b_busy, 1);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      check("t6_lat_not_yet", b_data_valid, 0);
    end
    tick(1);
    check("t6_lat_valid", b_data_valid, 1);
    check("t6_data", b_data_out, 4'hC);
    check("t6_addr", b_data_addr, 5'd9);
    tick(1);
    check("t6_done", b_done, 1);
    check("t6_sum", b_sum, 12);
    check("t6_no_second_word", b_data_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
